// File: rtl/serial_chunk_adder.sv
// Serial add/subtract, CHUNK bits per cycle LSB first; out_valid NCHUNK cycles after accept.
// Result held in DONE until out_ready; in_ready low whenever an operation is in flight.
module serial_chunk_adder #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [31:0]      base;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK:0]   chunk_sum;
    logic             msb_cin;
    logic             last_chunk;

    always_comb begin
        base       = 32'(k_q) * 32'(CHUNK);
        chunk_a    = a_q[base +: CHUNK];
        chunk_b    = b_q[base +: CHUNK];
        chunk_sum  = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
        // Carry into the top bit of the chunk recovered from the sum bit itself.
        msb_cin    = chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1] ^ chunk_sum[CHUNK-1];
        last_chunk = (k_q == KW'(NCHUNK - 1));
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : carry_in;
                    k_d     = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                sum_d[base +: CHUNK] = chunk_sum[CHUNK-1:0];
                carry_d              = chunk_sum[CHUNK];
                if (last_chunk) begin
                    cout_d  = chunk_sum[CHUNK];
                    ovf_d   = msb_cin ^ chunk_sum[CHUNK];
                    k_d     = '0;
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE) && rst_n;
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Bench for serial_chunk_adder: three instances (CHUNK 1, 4, 16) at WIDTH 16,
// directed cases on the CHUNK=4 instance and randomised stalled traffic on all three.
module tb_serial_chunk_adder;

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] a, b;
    logic        carry_in, sub;
    logic [2:0]  in_valid_v, in_ready_v, out_valid_v, out_ready_v;
    logic [2:0]  carry_out_v, overflow_v;
    logic [15:0] sum_v [3];

    exp_t sb[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int CH = (g == 0) ? 1 : ((g == 1) ? 4 : 16);
        serial_chunk_adder #(.WIDTH(16), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a),
            .b         (b),
            .carry_in  (carry_in),
            .sub       (sub),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .sum       (sum_v[g]),
            .carry_out (carry_out_v[g]),
            .overflow  (overflow_v[g])
        );
    end

    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y,
                                   input logic c, input logic s);
        logic [16:0] f;
        exp_t r;
        if (s) f = {1'b0, x} + {1'b0, ~y} + 17'd1;
        else   f = {1'b0, x} + {1'b0, y} + {16'd0, c};
        r.s  = f[15:0];
        r.co = f[16];
        if (s) r.ov = (x[15] != y[15]) && (f[15] != x[15]);
        else   r.ov = (x[15] == y[15]) && (f[15] != x[15]);
        return r;
    endfunction

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 16'h0000;
            1:       return 16'hFFFF;
            2:       return 16'h7FFF;
            3:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    // Called right after a negedge; returns right after the negedge following the accept edge.
    task automatic send(input int idx, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic tc, input logic ts);
        int w = 0;
        while (!in_ready_v[idx] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready_v[idx]) begin
            n_cmp++;
            n_fail++;
            $display("FAIL send_ready inst%0d: in_ready=%b required 1", idx, in_ready_v[idx]);
        end
        a = ta; b = tb_; carry_in = tc; sub = ts;
        in_valid_v[idx] = 1'b1;
        sb.push_back(model(ta, tb_, tc, ts));
        @(negedge clk);
        in_valid_v[idx] = 1'b0;
    endtask

    task automatic wait_out(input int idx, output int cyc);
        cyc = 0;
        while (!out_valid_v[idx] && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid_v = '0; out_ready_v = '0;
        a = 16'hA5A5; b = 16'h5A5A; carry_in = 1'b1; sub = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready_v, out_valid_v, carry_out_v, overflow_v} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_flags: rdy=%b vld=%b co=%b ov=%b required all 0",
                     in_ready_v, out_valid_v, carry_out_v, overflow_v);
        end
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (sum_v[i] !== 16'h0000) begin
                n_fail++;
                $display("FAIL reset_sum inst%0d: got %h required 0000", i, sum_v[i]);
            end
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (in_ready_v !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b required 111", in_ready_v);
        end
        @(negedge clk);
    endtask

    task automatic run_table(input string name, input logic is_sub);
        logic [15:0] ta [4];
        logic [15:0] tbv [4];
        logic        tc [4];
        exp_t        e;
        int          cyc;
        if (is_sub) begin
            ta = '{16'h0003, 16'h8000, 16'h0003, 16'h8000};
            tbv = '{16'h0006, 16'h0001, 16'h0006, 16'h0001};
            tc = '{1'b0, 1'b0, 1'b1, 1'b1};
        end else begin
            ta = '{16'h0000, 16'h0000, 16'hFFFF, 16'h7FFF};
            tbv = '{16'h0000, 16'h0000, 16'h0001, 16'h0001};
            tc = '{1'b0, 1'b1, 1'b0, 1'b0};
        end
        out_ready_v[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send(1, ta[i], tbv[i], tc[i], is_sub);
            wait_out(1, cyc);
            n_cmp++;
            if (cyc != 4) begin
                n_fail++;
                $display("FAIL %s_latency case%0d: got %0d cycles required 4", name, i, cyc);
            end
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            n_cmp++;
            if ({sum_v[1], carry_out_v[1], overflow_v[1]} !== e) begin
                n_fail++;
                $display("FAIL %s_result case%0d: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                         name, i, sum_v[1], carry_out_v[1], overflow_v[1], e.s, e.co, e.ov);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add();
        run_table("add", 1'b0);
    endtask

    task automatic test_sub();
        run_table("sub", 1'b1);
    endtask

    task automatic test_hold();
        exp_t e;
        int   cyc;
        out_ready_v[1] = 1'b0;
        send(1, 16'h1234, 16'h0FFF, 1'b0, 1'b0);
        wait_out(1, cyc);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); carry_in = 1'($urandom);
            in_valid_v[1] = 1'b1;
            @(negedge clk);
            n_cmp++;
            if ({out_valid_v[1], in_ready_v[1], sum_v[1], carry_out_v[1], overflow_v[1]} !== {2'b10, e}) begin
                n_fail++;
                $display("FAIL hold cyc%0d: got vld=%b rdy=%b sum=%h co=%b ov=%b required vld=1 rdy=0 sum=%h co=%b ov=%b",
                         i, out_valid_v[1], in_ready_v[1], sum_v[1], carry_out_v[1], overflow_v[1], e.s, e.co, e.ov);
            end
        end
        in_valid_v[1] = 1'b0;
        out_ready_v[1] = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({out_valid_v[1], in_ready_v[1], sum_v[1]} !== {2'b01, e.s}) begin
            n_fail++;
            $display("FAIL hold_release: got vld=%b rdy=%b sum=%h required vld=0 rdy=1 sum=%h",
                     out_valid_v[1], in_ready_v[1], sum_v[1], e.s);
        end
        send(1, 16'h0101, 16'h0202, 1'b0, 1'b1);
        wait_out(1, cyc);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if ({sum_v[1], carry_out_v[1], overflow_v[1]} !== e || cyc != 4) begin
            n_fail++;
            $display("FAIL hold_next_op: got sum=%h co=%b ov=%b lat=%0d required sum=%h co=%b ov=%b lat=4",
                     sum_v[1], carry_out_v[1], overflow_v[1], cyc, e.s, e.co, e.ov);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_abort();
        exp_t e;
        int   cyc;
        out_ready_v[1] = 1'b1;
        send(1, 16'h1111, 16'h2222, 1'b0, 1'b0);
        void'(sb.pop_back());
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if ({in_ready_v[1], out_valid_v[1], sum_v[1]} !== {2'b10, 16'h0000}) begin
            n_fail++;
            $display("FAIL abort_state: got rdy=%b vld=%b sum=%h required rdy=1 vld=0 sum=0000",
                     in_ready_v[1], out_valid_v[1], sum_v[1]);
        end
        repeat (6) @(negedge clk);
        n_cmp++;
        if (out_valid_v !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_no_result: got vld=%b required 000", out_valid_v);
        end
        send(1, 16'h1234, 16'h4321, 1'b0, 1'b0);
        wait_out(1, cyc);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (sum_v[1] !== 16'h5555 || {sum_v[1], carry_out_v[1], overflow_v[1]} !== e || cyc != 4) begin
            n_fail++;
            $display("FAIL abort_next_op: got sum=%h co=%b ov=%b lat=%0d required sum=5555 co=0 ov=0 lat=4",
                     sum_v[1], carry_out_v[1], overflow_v[1], cyc);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        localparam int NOPS = 40;
        exp_t        e;
        logic [15:0] ra, rb;
        logic        rc, rs;
        for (int idx = 0; idx < 3; idx++) begin
            int sent = 0;
            int done = 0;
            int cyc  = 0;
            sb.delete();
            while (done < NOPS && cyc < 6000) begin
                out_ready_v[idx] = ($urandom_range(0, 3) != 0);
                if (out_valid_v[idx] && out_ready_v[idx]) begin
                    n_cmp++;
                    if (sb.size() == 0) begin
                        n_fail++;
                        $display("FAIL b2b_unexpected inst%0d: got sum=%h with empty scoreboard required no output",
                                 idx, sum_v[idx]);
                    end else begin
                        e = sb.pop_front();
                        if ({sum_v[idx], carry_out_v[idx], overflow_v[idx]} !== e) begin
                            n_fail++;
                            $display("FAIL b2b inst%0d op%0d: got sum=%h co=%b ov=%b required sum=%h co=%b ov=%b",
                                     idx, done, sum_v[idx], carry_out_v[idx], overflow_v[idx], e.s, e.co, e.ov);
                        end
                    end
                    done++;
                end
                ra = pick_operand(); rb = pick_operand();
                rc = 1'($urandom); rs = 1'($urandom);
                a = ra; b = rb; carry_in = rc; sub = rs;
                if (in_ready_v[idx]) begin
                    if (sent < NOPS && $urandom_range(0, 3) != 0) begin
                        in_valid_v[idx] = 1'b1;
                        sb.push_back(model(ra, rb, rc, rs));
                        sent++;
                    end else begin
                        in_valid_v[idx] = 1'b0;
                    end
                end else begin
                    in_valid_v[idx] = 1'($urandom);
                end
                @(negedge clk);
                cyc++;
            end
            in_valid_v[idx]  = 1'b0;
            out_ready_v[idx] = 1'b0;
            if (done < NOPS) begin
                n_cmp++;
                n_fail++;
                $display("FAIL b2b_timeout inst%0d: got %0d results required %0d", idx, done, NOPS);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_hold();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete, required completion before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/serial_chunk_adder.md
SERIAL_CHUNK_ADDER -- requirements
Module: serial_chunk_adder

Interface
REQ-001 SHALL provide parameter WIDTH, default 16, operand and result width in bits.
REQ-002 SHALL provide parameter CHUNK, default 4, bits added per clock; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operands and mode on a, b, carry_in, sub are valid.
REQ-006 SHALL have port in_ready  output  1  block can accept an operation.
REQ-007 SHALL have port a  input  WIDTH  operand A.
REQ-008 SHALL have port b  input  WIDTH  operand B.
REQ-009 SHALL have port carry_in  input  1  carry into bit 0; add mode only.
REQ-010 SHALL have port sub  input  1  0 = A+B+carry_in, 1 = A-B (A + ~B + 1, carry_in ignored).
REQ-011 SHALL have port out_valid  output  1  result outputs valid.
REQ-012 SHALL have port out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port sum  output  WIDTH  result, modulo 2^WIDTH.
REQ-014 SHALL have port carry_out  output  1  carry out of bit WIDTH-1 (sub: 1 = no borrow).
REQ-015 SHALL have port overflow  output  1  two's-complement overflow: carry into MSB XOR carry out of MSB.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; one operation in flight, no overlap.
REQ-017 in_ready SHALL be 1 only in IDLE with rst_n high; 0 in RUN and DONE.
REQ-018 On the edge with in_valid && in_ready: latch a, b (inverted if sub), initial carry (carry_in, or 1 if sub), clear chunk counter, go RUN.
REQ-019 In RUN, each edge SHALL add chunk k (bits k*CHUNK+CHUNK-1 : k*CHUNK) plus the stored carry, write that chunk of sum, store the new carry, increment k; order LSB chunk first.
REQ-020 After the edge processing chunk NCHUNK-1, SHALL enter DONE with out_valid = 1; latency = NCHUNK edges from accept edge to out_valid high (NCHUNK = 1 gives 1 cycle).
REQ-021 carry_out and overflow SHALL be taken from the final chunk; overflow SHALL use the carry into bit WIDTH-1.
REQ-022 In DONE, out_valid, sum, carry_out, overflow SHALL hold stable until out_valid && out_ready; on that edge go IDLE, out_valid = 0.
REQ-023 sum, carry_out, overflow SHALL retain the last result in IDLE until the next accept; partially written sum in RUN is not valid (out_valid = 0).
REQ-024 in_valid in RUN or DONE SHALL be ignored; inputs a, b, sub, carry_in changing after accept SHALL not affect the result.
REQ-025 out_ready outside DONE SHALL have no effect.

Reset
REQ-026 While rst_n low on an edge: state IDLE, chunk counter 0, out_valid 0, sum 0, carry_out 0, overflow 0, internal carry/operands 0.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation with no result; in_ready = 1 in the first cycle after rst_n returns high.

Verification (WIDTH=16, CHUNK=4)
REQ-028 Add 0x0000+0x0000, carry_in 0 -> out_valid exactly 4 cycles after accept, sum 0x0000, carry_out 0, overflow 0; same with carry_in 1 -> sum 0x0001.
REQ-029 Add 0xFFFF+0x0001 -> sum 0x0000, carry_out 1, overflow 0 (carry through all 4 chunks); 0x7FFF+0x0001 -> 0x8000, carry_out 0, overflow 1.
REQ-030 Sub 0x0003-0x0006 -> 0xFFFD, carry_out 0, overflow 0; sub 0x8000-0x0001 -> 0x7FFF, carry_out 1, overflow 1; carry_in = 1 with sub does not change results.
REQ-031 Hold out_ready 0 for 5 cycles in DONE while driving in_valid with new operands -> out_valid and outputs stable, in_ready 0, no accept; out_ready 1 -> IDLE next cycle, then new op accepted and correct.
REQ-032 rst_n low at the edge where chunk 2 would be processed -> next cycle IDLE, out_valid 0, sum 0; following op 0x1234+0x4321 -> 0x5555.
REQ-033 Randomised back-to-back ops with random out_ready stalls, both modes, CHUNK in {1,4,16} -> every result matches (a ± b) reference model, including carry_out and overflow.
